// File: rtl/keymgr_pkg.sv
// Shared types and defaults for the key manager slice.
// Optional watchdog is compiled in with KEYMGR_WATCHDOG_EN.
package keymgr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_N,
        WAIT_E,
        WAIT_D
    } state_t;

    localparam int KEYMGR_KEY_W          = 32;
    localparam int KEYMGR_TIMEOUT_CYCLES = 16777216;
    localparam int KEYMGR_CNT_W          = $clog2(KEYMGR_TIMEOUT_CYCLES);

endpackage

// File: rtl/keymgr_watchdog.sv
// Wait-state watchdog: counts cycles since the last accepted strobe.
// Instantiated by key_manager only when KEYMGR_WATCHDOG_EN is defined.
module keymgr_watchdog
    import keymgr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = KEYMGR_TIMEOUT_CYCLES,
    parameter int CNT_W          = KEYMGR_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = inc && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/key_manager.sv
// Key-generator consumer: captures n/e/d strobes and commits them atomically.
// Define KEYMGR_WATCHDOG_EN to bound each wait state by TIMEOUT_CYCLES.
module key_manager
    import keymgr_pkg::*;
#(
    parameter int KEY_W          = KEYMGR_KEY_W,
    parameter int TIMEOUT_CYCLES = KEYMGR_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_req,
    input  logic             clear,
    output logic             kg_start,
    input  logic             kg_busy,
    input  logic [KEY_W-1:0] kg_n_key,
    input  logic [KEY_W-1:0] kg_e_key,
    input  logic [KEY_W-1:0] kg_d_key,
    input  logic             kg_n_valid,
    input  logic             kg_e_valid,
    input  logic             kg_d_valid,
    output logic [KEY_W-1:0] n_key,
    output logic [KEY_W-1:0] e_key,
    output logic [KEY_W-1:0] d_key,
    output logic             keys_valid,
    output logic             gen_busy,
    output logic             new_keys,
    output logic             gen_abort
);

    state_t           state;
    logic [KEY_W-1:0] n_shadow;
    logic [KEY_W-1:0] e_shadow;
    logic             in_wait;
    logic             strobe_hit;
    logic             timeout;

    // Only the strobe belonging to the current wait state counts.
    always_comb begin
        in_wait    = 1'b0;
        strobe_hit = 1'b0;
        case (state)
            WAIT_N:  begin in_wait = 1'b1; strobe_hit = kg_n_valid; end
            WAIT_E:  begin in_wait = 1'b1; strobe_hit = kg_e_valid; end
            WAIT_D:  begin in_wait = 1'b1; strobe_hit = kg_d_valid; end
            default: begin in_wait = 1'b0; strobe_hit = 1'b0;       end
        endcase
    end

`ifdef KEYMGR_WATCHDOG_EN
    logic wd_expired;

    keymgr_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         ($clog2(TIMEOUT_CYCLES))
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_wait || strobe_hit || clear),
        .inc    (in_wait),
        .expired(wd_expired)
    );

    assign timeout = wd_expired;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_shadow   <= '0;
            e_shadow   <= '0;
            n_key      <= '0;
            e_key      <= '0;
            d_key      <= '0;
            keys_valid <= 1'b0;
            kg_start   <= 1'b0;
            gen_busy   <= 1'b0;
            new_keys   <= 1'b0;
            gen_abort  <= 1'b0;
        end else begin
            kg_start  <= 1'b0;
            new_keys  <= 1'b0;
            gen_abort <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                n_shadow   <= '0;
                e_shadow   <= '0;
                n_key      <= '0;
                e_key      <= '0;
                d_key      <= '0;
                keys_valid <= 1'b0;
                gen_busy   <= 1'b0;
                gen_abort  <= (state != IDLE);
            end else if (in_wait && !strobe_hit && (!kg_busy || timeout)) begin
                state     <= IDLE;
                gen_busy  <= 1'b0;
                gen_abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (gen_req) begin
                            state    <= START;
                            kg_start <= 1'b1;
                            gen_busy <= 1'b1;
                        end
                    end
                    START: state <= WAIT_N;
                    WAIT_N: begin
                        if (kg_n_valid) begin
                            n_shadow <= kg_n_key;
                            state    <= WAIT_E;
                        end
                    end
                    WAIT_E: begin
                        if (kg_e_valid) begin
                            e_shadow <= kg_e_key;
                            state    <= WAIT_D;
                        end
                    end
                    WAIT_D: begin
                        if (kg_d_valid) begin
                            n_key      <= n_shadow;
                            e_key      <= e_shadow;
                            d_key      <= kg_d_key;
                            keys_valid <= 1'b1;
                            new_keys   <= 1'b1;
                            gen_busy   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        gen_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_manager.sv
// Self-checking bench for key_manager against a cycle-schedule reference model.
// Watchdog expectations follow KEYMGR_WATCHDOG_EN when it is defined.
module tb_key_manager;

    localparam int KEY_W = 32;
    localparam int WD_T  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             gen_req, clear, kg_start, kg_busy;
    logic [KEY_W-1:0] kg_n_key, kg_e_key, kg_d_key;
    logic             kg_n_valid, kg_e_valid, kg_d_valid;
    logic [KEY_W-1:0] n_key, e_key, d_key;
    logic             keys_valid, gen_busy, new_keys, gen_abort;

    int checks   = 0;
    int failures = 0;

    // Reference view of the committed key set.
    logic [KEY_W-1:0] exp_n = '0, exp_e = '0, exp_d = '0;
    logic             exp_v = 1'b0;

    key_manager #(.KEY_W(KEY_W), .TIMEOUT_CYCLES(WD_T)) dut (
        .clk(clk), .rst(rst), .gen_req(gen_req), .clear(clear),
        .kg_start(kg_start), .kg_busy(kg_busy),
        .kg_n_key(kg_n_key), .kg_e_key(kg_e_key), .kg_d_key(kg_d_key),
        .kg_n_valid(kg_n_valid), .kg_e_valid(kg_e_valid), .kg_d_valid(kg_d_valid),
        .n_key(n_key), .e_key(e_key), .d_key(d_key), .keys_valid(keys_valid),
        .gen_busy(gen_busy), .new_keys(new_keys), .gen_abort(gen_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim time exceeded, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic idle_inputs();
        gen_req    = 1'b0;
        clear      = 1'b0;
        kg_n_valid = 1'b0;
        kg_e_valid = 1'b0;
        kg_d_valid = 1'b0;
        kg_n_key   = $urandom;
        kg_e_key   = $urandom;
        kg_d_key   = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kg_busy = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({n_key, e_key, d_key, keys_valid} !== '0) begin
            failures++;
            $display("FAIL reset_keys got n=%h e=%h d=%h v=%b required all zero", n_key, e_key, d_key, keys_valid);
        end
        checks++;
        if ({kg_start, gen_busy, new_keys, gen_abort} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got start/busy/new/abort=%b required 0000",
                     {kg_start, gen_busy, new_keys, gen_abort});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({kg_start, gen_busy, new_keys, gen_abort, keys_valid} !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle got %b required 00000",
                     {kg_start, gen_busy, new_keys, gen_abort, keys_valid});
        end
    endtask

    // One complete generation: gen_req at edge 0, strobes at scheduled edges,
    // optional ignorable stray strobes/requests; outputs checked every cycle.
    task automatic run_gen(input logic [KEY_W-1:0] n, input logic [KEY_W-1:0] e,
                           input logic [KEY_W-1:0] d, input int unsigned gn,
                           input int unsigned ge, input int unsigned gd,
                           input bit strays, input bit stray_e_first, input string tag);
        int unsigned n_at, e_at, d_at;
        logic [KEY_W-1:0] wn, we, wd;
        logic wv;
        n_at = 2 + gn;
        e_at = n_at + 1 + ge;
        d_at = e_at + 1 + gd;
        for (int unsigned c = 0; c <= d_at + 3; c++) begin
            clear      = 1'b0;
            kg_busy    = (c >= 1 && c <= d_at);
            gen_req    = (c == 0) || (strays && c >= 1 && c <= d_at && $urandom_range(3) == 0);
            kg_n_valid = (c == n_at);
            kg_e_valid = (c == e_at);
            kg_d_valid = (c == d_at);
            if (strays) begin
                if (c < 2 || c > n_at) kg_n_valid = kg_n_valid | ($urandom_range(2) == 0);
                if (c <= n_at || c > e_at) kg_e_valid = kg_e_valid | ($urandom_range(2) == 0);
                if (c <= e_at || c > d_at) kg_d_valid = kg_d_valid | ($urandom_range(2) == 0);
            end
            kg_n_key = (c == n_at) ? n : KEY_W'($urandom);
            kg_e_key = (c == e_at) ? e : KEY_W'($urandom);
            kg_d_key = (c == d_at) ? d : KEY_W'($urandom);
            if (stray_e_first && c == 2) begin
                kg_e_valid = 1'b1;
                kg_e_key   = 32'h5;
            end
            tick();
            if (c >= d_at) begin wn = n; we = e; wd = d; wv = 1'b1; end
            else begin wn = exp_n; we = exp_e; wd = exp_d; wv = exp_v; end
            checks++;
            if ({n_key, e_key, d_key, keys_valid} !== {wn, we, wd, wv}) begin
                failures++;
                $display("FAIL %s keys c=%0d got n=%h e=%h d=%h v=%b required n=%h e=%h d=%h v=%b",
                         tag, c, n_key, e_key, d_key, keys_valid, wn, we, wd, wv);
            end
            checks++;
            if ({kg_start, new_keys, gen_busy, gen_abort} !== {(c == 0), (c == d_at), (c < d_at), 1'b0}) begin
                failures++;
                $display("FAIL %s ctrl c=%0d got start/new/busy/abort=%b required %b", tag, c,
                         {kg_start, new_keys, gen_busy, gen_abort},
                         {(c == 0), (c == d_at), (c < d_at), 1'b0});
            end
        end
        exp_n = n; exp_e = e; exp_d = d; exp_v = 1'b1;
        idle_inputs();
        kg_busy = 1'b0;
    endtask

    task automatic test_normal();
        run_gen(32'h0000_0D09, 32'h11, 32'h0000_0A61, 1, 3, 4, 1'b0, 1'b0, "normal");
    endtask

    task automatic test_regen();
        run_gen($urandom, $urandom, $urandom, $urandom_range(4), $urandom_range(4),
                $urandom_range(4), 1'b1, 1'b0, "regen");
    endtask

    task automatic test_ordering();
        run_gen(32'h1234, 32'h7, 32'h9, 1, 0, 0, 1'b0, 1'b1, "ordering");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_gen($urandom, $urandom, $urandom, 0, 0, 0, 1'b1, 1'b0, "back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_gen($urandom, $urandom, $urandom, $urandom_range(5), $urandom_range(5),
                    $urandom_range(5), 1'b1, 1'b0, "random");
    endtask

    // kg_busy drops with no strobe in WAIT_N, WAIT_E, WAIT_D in turn.
    task automatic test_abort();
        for (int unsigned s = 0; s < 3; s++) begin
            int unsigned a;
            a = 2 + s;
            for (int unsigned c = 0; c <= a + 2; c++) begin
                idle_inputs();
                gen_req    = (c == 0);
                kg_busy    = (c >= 1 && c < a);
                kg_n_valid = (s >= 1 && c == 2);
                kg_e_valid = (s >= 2 && c == 3);
                tick();
                checks++;
                if ({gen_abort, gen_busy} !== {(c == a), (c < a)}) begin
                    failures++;
                    $display("FAIL abort_s%0d ctrl c=%0d got abort/busy=%b required %b", s, c,
                             {gen_abort, gen_busy}, {(c == a), (c < a)});
                end
                checks++;
                if ({n_key, e_key, d_key, keys_valid} !== {exp_n, exp_e, exp_d, exp_v}) begin
                    failures++;
                    $display("FAIL abort_s%0d keys c=%0d got n=%h e=%h d=%h v=%b required n=%h e=%h d=%h v=%b",
                             s, c, n_key, e_key, d_key, keys_valid, exp_n, exp_e, exp_d, exp_v);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int unsigned c = 0; c <= 5; c++) begin
            idle_inputs();
            gen_req    = (c == 0) || (c == 4);
            kg_busy    = (c >= 1);
            kg_n_valid = (c == 2);
            kg_e_valid = (c == 3);
            kg_d_valid = (c == 4);
            clear      = (c == 4);
            tick();
            if (c >= 4) begin
                checks++;
                if ({n_key, e_key, d_key, keys_valid} !== '0) begin
                    failures++;
                    $display("FAIL clear_keys c=%0d got n=%h e=%h d=%h v=%b required all zero",
                             c, n_key, e_key, d_key, keys_valid);
                end
                checks++;
                if ({kg_start, new_keys, gen_busy, gen_abort} !== {3'b000, (c == 4)}) begin
                    failures++;
                    $display("FAIL clear_ctrl c=%0d got start/new/busy/abort=%b required %b",
                             c, {kg_start, new_keys, gen_busy, gen_abort}, {3'b000, (c == 4)});
                end
            end
        end
        exp_n = '0; exp_e = '0; exp_d = '0; exp_v = 1'b0;
        idle_inputs();
        kg_busy = 1'b0;
    endtask

    task automatic test_clear_idle();
        run_gen($urandom, $urandom, $urandom, 1, 1, 1, 1'b0, 1'b0, "pre_clear");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({n_key, e_key, d_key, keys_valid, gen_abort} !== '0) begin
            failures++;
            $display("FAIL clear_idle got n=%h e=%h d=%h v=%b abort=%b required all zero",
                     n_key, e_key, d_key, keys_valid, gen_abort);
        end
        exp_n = '0; exp_e = '0; exp_d = '0; exp_v = 1'b0;
    endtask

    task automatic test_rst_mid();
        run_gen($urandom, $urandom, $urandom, 0, 1, 0, 1'b0, 1'b0, "pre_rst");
        for (int unsigned c = 0; c <= 3; c++) begin
            idle_inputs();
            gen_req    = (c == 0);
            kg_busy    = (c >= 1);
            kg_n_valid = (c == 2);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({n_key, e_key, d_key, keys_valid, gen_busy, gen_abort, kg_start, new_keys} !== '0) begin
            failures++;
            $display("FAIL rst_mid got n=%h e=%h d=%h v=%b busy=%b abort=%b required all zero",
                     n_key, e_key, d_key, keys_valid, gen_busy, gen_abort);
        end
        @(negedge clk);
        rst = 1'b0;
        kg_busy = 1'b0;
        tick();
        checks++;
        if ({gen_abort, gen_busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_after got abort/busy=%b required 00", {gen_abort, gen_busy});
        end
        exp_n = '0; exp_e = '0; exp_d = '0; exp_v = 1'b0;
    endtask

    // n captured at edge 2; no further strobes while kg_busy stays high.
    task automatic test_watchdog();
        int unsigned last;
        bit          wd_on;
`ifdef KEYMGR_WATCHDOG_EN
        wd_on = 1'b1;
`else
        wd_on = 1'b0;
`endif
        last = wd_on ? (2 + WD_T + 2) : 42;
        for (int unsigned c = 0; c <= last; c++) begin
            idle_inputs();
            gen_req    = (c == 0);
            kg_busy    = (c >= 1);
            kg_n_valid = (c == 2);
            tick();
            checks++;
            if (gen_abort !== (wd_on && c == 2 + WD_T)) begin
                failures++;
                $display("FAIL watchdog c=%0d got abort=%b required %b", c, gen_abort,
                         (wd_on && c == 2 + WD_T));
            end
        end
        if (!wd_on) begin
            checks++;
            if (gen_busy !== 1'b1) begin
                failures++;
                $display("FAIL no_watchdog_busy got %b required 1", gen_busy);
            end
            kg_busy = 1'b0;
            tick();
            checks++;
            if ({gen_abort, gen_busy} !== 2'b10) begin
                failures++;
                $display("FAIL no_watchdog_drop got abort/busy=%b required 10", {gen_abort, gen_busy});
            end
        end
        checks++;
        if ({n_key, e_key, d_key, keys_valid} !== {exp_n, exp_e, exp_d, exp_v}) begin
            failures++;
            $display("FAIL watchdog_keys got n=%h e=%h d=%h v=%b required n=%h e=%h d=%h v=%b",
                     n_key, e_key, d_key, keys_valid, exp_n, exp_e, exp_d, exp_v);
        end
        kg_busy = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_regen();
        test_ordering();
        test_back_to_back();
        test_abort();
        test_random();
        test_clear();
        test_clear_idle();
        test_rst_mid();
        test_regen();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_manager.md
# key_manager

Consumer end of the key-generation interface. Issues a one-cycle start pulse to the key generator, then captures the sequentially produced n, e and d keys from their one-cycle valid strobes. It commits the three keys atomically to holding registers that feed the encrypt/decrypt datapath. Previously committed keys stay usable until a complete new set arrives.

## Interface
- KEY_W, 32: key width in bits.
- TIMEOUT_CYCLES, 16777216: watchdog limit in clk cycles, used only when the watchdog is compiled in.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- gen_req  in  1  one-cycle request for a new key set.
- clear  in  1  wipes committed keys and aborts any generation.
- kg_start  out  1  start pulse to the generator, registered.
- kg_busy  in  1  generator busy flag.
- kg_n_key, kg_e_key, kg_d_key  in  KEY_W each  generator key buses.
- kg_n_valid, kg_e_valid, kg_d_valid  in  1 each  one-cycle key strobes.
- n_key, e_key, d_key  out  KEY_W each  committed keys.
- keys_valid  out  1  a committed key set exists.
- gen_busy  out  1  generation in progress.
- new_keys  out  1  one-cycle pulse when a new set is committed.
- gen_abort  out  1  one-cycle pulse when a generation is abandoned.

## Operation
- FSM states: IDLE, START, WAIT_N, WAIT_E, WAIT_D.
- IDLE:
  - gen_req → START.
  - All kg_*_valid inputs are ignored.
- START:
  - kg_start = 1 for exactly this cycle.
  - Next state is always WAIT_N.
- WAIT_N: on kg_n_valid, capture kg_n_key into the shadow n register → WAIT_E.
- WAIT_E: on kg_e_valid, capture the shadow e register → WAIT_D.
- WAIT_D: on kg_d_valid:
  - Load n_key, e_key and d_key in the same edge: n and e from the shadow registers, d directly from kg_d_key.
  - keys_valid ← 1, new_keys pulses → IDLE.
- In a WAIT_* state, only the strobe expected by that state is honoured. Other strobes, including ones arriving in the same cycle, are ignored.
- kg_busy low in any WAIT_* state without the expected strobe present: pulse gen_abort → IDLE. The committed keys and keys_valid are unchanged.
- gen_req outside IDLE is ignored. It is not queued.
- clear, from any state:
  - Next state IDLE.
  - n_key, e_key, d_key, the shadow registers and keys_valid are all zeroed.
  - gen_abort pulses if the FSM was not in IDLE.
  - clear wins over a simultaneous gen_req or strobe.
- gen_busy = 1 in every state except IDLE.
- Keys are never partially updated. Outputs change only on commit, clear or rst.

## Timing
- Reset values, for all outputs and the shadow registers: 0; FSM in IDLE.
- gen_req sampled at edge t → kg_start high during cycle t..t+1 → WAIT_N from edge t+1.
- The generator raises kg_busy from edge t+1, so kg_busy is high on entry to WAIT_N.
- Strobe sampled at edge k → the state advances at edge k. For kg_d_valid, the new key outputs and new_keys are visible during cycle k..k+1.
- A strobe on the cycle directly after the previous capture is accepted (back-to-back strobes supported).
- The generator drops kg_busy the cycle after kg_d_valid. The FSM is already in IDLE by then, so this is not an abort.
- rst asserted mid-generation: immediate return to IDLE with all registers zeroed. No gen_abort pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- KEYMGR_WATCHDOG_EN defined:
  - A counter clears on entry to START and on every accepted strobe.
  - It increments each cycle in a WAIT_* state.
  - Reaching TIMEOUT_CYCLES−1 with no expected strobe present → gen_abort, IDLE, committed keys retained.
- KEYMGR_WATCHDOG_EN undefined: no counter. Waits are unbounded except for the kg_busy abort rule.

## Structure
- Package keymgr_pkg holds:
  - the state enum;
  - the KEY_W default;
  - the TIMEOUT_CYCLES default;
  - the counter width, derived as $clog2(TIMEOUT_CYCLES).
- One sub-module, keymgr_watchdog: counter plus expiry flag, instantiated only under KEYMGR_WATCHDOG_EN.
- The shadow registers and the FSM stay in key_manager.

## Test plan
- Normal generation:
  - Stimulus: gen_req; model drives kg_busy high from the next cycle; strobes n=0x0000_0D09, e=0x11, d=0x0000_0A61 on cycles 3, 7, 12.
  - Response: kg_start pulses once; new_keys pulses once; outputs show exactly those values; keys_valid = 1.
- Regeneration keeps old keys:
  - Stimulus: with set A committed, gen_req, then strobes of set B.
  - Response: outputs hold A until the cycle after B's d strobe, then switch to B in a single cycle.
- Ordering:
  - Stimulus: e strobe (0x5) arrives in WAIT_N, then n=0x1234, e=0x7, d=0x9.
  - Response: the stray e is ignored; the committed e = 0x7.
- Abort:
  - Stimulus: kg_busy drops in WAIT_E with no strobe.
  - Response: gen_abort pulses once; the prior keys and keys_valid are unchanged; gen_busy = 0.
- Clear priority:
  - Stimulus: clear and gen_req in the same cycle during WAIT_D, together with kg_d_valid.
  - Response: all keys 0; keys_valid = 0; no kg_start; gen_abort pulses.
- Watchdog (KEYMGR_WATCHDOG_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: no strobe after the n capture.
  - Response: gen_abort exactly 8 cycles after the n capture.
  - Macro undefined: no abort.
